// File: rtl/pair_generator_pkg.sv
// Shared definitions for the pair generator: FSM encoding, sizing constants
// and the lowest-unused-index priority encoder.
package pair_generator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    localparam int LED_CNT = 16;
    localparam int IDX_W   = 4;
    localparam int SLOTS   = 6;

    // Scans from the top down so the last hit wins, leaving the lowest free index.
    function automatic logic [IDX_W-1:0] lowest_unused(input logic [LED_CNT-1:0] used);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = LED_CNT - 1; i >= 0; i--) begin
            if (!used[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pair_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting); never held, so the moment
// a request arrives decides which values get drawn.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= SEED;
        end else if (r_q[0]) begin
            r_q <= (r_q >> 1) ^ TAPS;
        end else begin
            r_q <= r_q >> 1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pair_generator.sv
// Draws six distinct LED indices per request and publishes them together on
// A..F with a one-cycle done pulse; pairs are (A,F), (B,E), (C,D).
module pair_generator
    import pair_generator_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [15:0] TAPS      = 16'hB400,
    parameter int          MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] A,
    output logic [IDX_W-1:0] B,
    output logic [IDX_W-1:0] C,
    output logic [IDX_W-1:0] D,
    output logic [IDX_W-1:0] E,
    output logic [IDX_W-1:0] F,
    output logic             done,
    output logic             busy
);

    localparam int                TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);

    logic [15:0]                   w_lfsr;
    logic [IDX_W-1:0]              w_cand;
    logic                          w_hit;
    logic                          w_accept;
    logic [IDX_W-1:0]              w_pick;
    logic                          w_unused_lfsr;

    state_t                        r_state;
    logic [LED_CNT-1:0]            r_used;
    logic [2:0]                    r_slot;
    logic [TRY_W-1:0]              r_tries;
    logic [SLOTS-1:0][IDX_W-1:0]   r_shadow;
    logic [SLOTS-1:0][IDX_W-1:0]   r_out;
    logic                          r_done;
    logic                          r_busy;

    lfsr16 #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_cand        = w_lfsr[IDX_W-1:0];
    assign w_unused_lfsr = ^w_lfsr[15:IDX_W];
    assign w_hit         = r_used[w_cand];
    // Out of retries: fall back to the lowest free index so the round always finishes.
    assign w_accept      = !w_hit || (r_tries == TRY_LAST);
    assign w_pick        = w_hit ? lowest_unused(r_used) : w_cand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_used   <= '0;
            r_slot   <= '0;
            r_tries  <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_GEN;
                        r_busy  <= 1'b1;
                        r_used  <= '0;
                        r_slot  <= '0;
                        r_tries <= '0;
                    end
                end
                ST_GEN: begin
                    if (w_accept) begin
                        r_shadow[r_slot] <= w_pick;
                        r_used[w_pick]   <= 1'b1;
                        r_slot           <= r_slot + 3'd1;
                        r_tries          <= '0;
                        if (r_slot == 3'(SLOTS - 1)) begin
                            // Last slot bypasses its shadow so all six land on this edge.
                            r_out   <= {w_pick, r_shadow[4:0]};
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tries <= r_tries + TRY_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign A    = r_out[0];
    assign B    = r_out[1];
    assign C    = r_out[2];
    assign D    = r_out[3];
    assign E    = r_out[4];
    assign F    = r_out[5];
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_pair_generator.sv
// Bench for pair_generator: a default instance and a MAX_TRIES=1 instance
// share clock, reset and start; a predictor queues expected sets, a monitor checks them.
module tb_pair_generator;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam int          MT0  = 8;
    localparam int          MT1  = 1;

    typedef struct packed {
        logic [23:0] v;
        int unsigned due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  va[2], vb[2], vc[2], vd[2], ve[2], vf[2];
    logic        dn[2], bs[2];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [15:0] tb_lfsr;
    logic [15:0] seen   = '0;
    int          done_cnt[2] = '{0, 0};

    exp_t        exp_q[2][$];
    logic        pend[2]   = '{1'b0, 1'b0};
    logic        m_busy[2] = '{1'b0, 1'b0};
    int unsigned due_m[2]  = '{0, 0};
    exp_t        pe;

    logic [23:0] prev[2];
    logic        prev_dn[2] = '{1'b0, 1'b0};
    logic [23:0] mc;
    exp_t        me;

    pair_generator #(.SEED(SEED), .TAPS(TAPS), .MAX_TRIES(MT0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .A(va[0]), .B(vb[0]), .C(vc[0]), .D(vd[0]), .E(ve[0]), .F(vf[0]),
        .done(dn[0]), .busy(bs[0])
    );

    pair_generator #(.SEED(SEED), .TAPS(TAPS), .MAX_TRIES(MT1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .A(va[1]), .B(vb[1]), .C(vc[1]), .D(vd[1]), .E(ve[1]), .F(vf[1]),
        .done(dn[1]), .busy(bs[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) tb_lfsr <= SEED;
        else      tb_lfsr <= lstep(tb_lfsr);
    end

    function automatic logic [15:0] lstep(logic [15:0] l);
        return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    // Expected set and done cycle for a round whose first draw sees LFSR value l.
    function automatic exp_t predict(logic [15:0] l, int mt, int unsigned now);
        exp_t        r;
        logic [15:0] used  = '0;
        logic [15:0] cur_l = l;
        int          tries = 0;
        int          n     = 0;
        int          t     = 0;
        int          c;
        r.v = '0;
        while (n < 6) begin
            c = int'(cur_l[3:0]);
            t++;
            if (!used[c] || tries == mt - 1) begin
                if (used[c]) begin
                    for (int i = 15; i >= 0; i--) if (!used[i]) c = i;
                end
                used[c] = 1'b1;
                r.v[n*4 +: 4] = 4'(c);
                n++;
                tries = 0;
            end else begin
                tries++;
            end
            cur_l = lstep(cur_l);
        end
        r.due = now + t;
        return r;
    endfunction

    function automatic logic [23:0] cur(int k);
        return {vf[k], ve[k], vd[k], vc[k], vb[k], va[k]};
    endfunction

    function automatic bit distinct6(logic [23:0] v);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < i; j++)
                if (v[i*4 +: 4] == v[j*4 +: 4]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Predictor: decides when a round starts and queues its expected outcome.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                pend[k]   = 1'b0;
                m_busy[k] = 1'b0;
                exp_q[k].delete();
            end else begin
                if (pend[k]) begin
                    pend[k]   = 1'b0;
                    pe        = predict(tb_lfsr, (k == 0) ? MT0 : MT1, cyc);
                    exp_q[k].push_back(pe);
                    m_busy[k] = 1'b1;
                    due_m[k]  = pe.due;
                end
                if (m_busy[k] && cyc == due_m[k]) m_busy[k] = 1'b0;
                chk($sformatf("busy%0d", k), 32'(bs[k]), 32'(m_busy[k]));
                if (start && !m_busy[k]) pend[k] = 1'b1;
            end
        end
    end

    // Monitor: pops and compares whenever a DUT raises done.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mc = cur(k);
            if (!rst) begin
                chk($sformatf("rst_out%0d", k), 32'(mc), 32'd0);
                chk($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
            end else if (dn[k]) begin
                done_cnt[k]++;
                chk($sformatf("done_single%0d", k), 32'(prev_dn[k]), 32'd0);
                chk($sformatf("busy_at_done%0d", k), 32'(bs[k]), 32'd0);
                chk($sformatf("distinct%0d", k), 32'(distinct6(mc)), 32'd1);
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
                end else begin
                    me = exp_q[k].pop_front();
                    chk($sformatf("set%0d", k), 32'(mc), 32'(me.v));
                    chk($sformatf("latency_cycle%0d", k), cyc, me.due);
                end
                if (k == 0) for (int i = 0; i < 6; i++) seen[mc[i*4 +: 4]] = 1'b1;
            end else begin
                if (mc !== prev[k]) chk($sformatf("stable%0d", k), 32'(mc), 32'(prev[k]));
                while (exp_q[k].size() > 0 && exp_q[k][0].due < cyc) begin
                    chk($sformatf("missing_done%0d", k), 32'd0, 32'd1);
                    void'(exp_q[k].pop_front());
                end
            end
            prev[k]    = mc;
            prev_dn[k] = dn[k];
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((m_busy[0] || m_busy[1] || pend[0] || pend[1]) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int d0;

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 30; i++) begin
            repeat (i % 4) tick();
            pulse_start();
            wait_idle(100);
        end

        // second start while busy must be dropped
        d0 = done_cnt[0];
        pulse_start();
        tick();
        pulse_start();
        wait_idle(100);
        repeat (10) tick();
        chk("busy_start_ignored", 32'(done_cnt[0] - d0), 32'd1);

        // reset in the middle of a round
        d0 = done_cnt[0];
        pulse_start();
        tick();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_rst_out%0d", k), 32'(cur(k)), 32'd0);
            chk($sformatf("async_rst_done%0d", k), 32'(dn[k]), 32'd0);
            chk($sformatf("async_rst_busy%0d", k), 32'(bs[k]), 32'd0);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("aborted_no_done", 32'(done_cnt[0] - d0), 32'd0);
        pulse_start();
        wait_idle(100);
        chk("post_rst_round", 32'(done_cnt[0] - d0), 32'd1);

        // start held high: back-to-back rounds
        start = 1'b1;
        repeat (3000) tick();
        start = 1'b0;
        wait_idle(100);
        repeat (5) tick();

        chk("queue0_empty", 32'(exp_q[0].size()), 32'd0);
        chk("queue1_empty", 32'(exp_q[1].size()), 32'd0);
        chk("all_indices_seen", 32'(seen), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
